// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the RV32 pipeline control blocks: FSM state
// encodings, the NOP instruction word and default timing parameters.
package rv_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2,
    ST_STEP   = 2'd3
  } ctrl_state_t;

  localparam logic [31:0] NOP_INSN             = 32'h00000013;
  localparam int          DEFAULT_STALL_LIMIT  = 1024;
  localparam int          DEFAULT_DRAIN_CYCLES = 2;

endpackage

// File: rtl/stall_watchdog.sv
// Counts consecutive busy cycles and raises a sticky flag once the count
// reaches STALL_LIMIT. Purely observational; it never stalls the pipeline.
module stall_watchdog
  import rv_ctrl_pkg::*;
#(
  parameter int STALL_LIMIT = DEFAULT_STALL_LIMIT
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic busy,
  output logic stall_timeout
);

  localparam int CW = $clog2(STALL_LIMIT + 1);

  logic [CW-1:0] stall_cnt;

  // The flag rises on the edge that completes the STALL_LIMIT-th busy cycle.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      stall_cnt     <= '0;
      stall_timeout <= 1'b0;
    end else if (busy) begin
      if (stall_cnt != CW'(STALL_LIMIT)) begin
        stall_cnt <= stall_cnt + CW'(1);
      end
      if (stall_cnt >= CW'(STALL_LIMIT - 1)) begin
        stall_timeout <= 1'b1;
      end
    end else begin
      stall_cnt <= '0;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control for the 3-stage RV32 core: hold/flush/PC-load generation
// plus the debug run/halt/step FSM and a stall watchdog.
module pipe_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int STALL_LIMIT  = DEFAULT_STALL_LIMIT,
  parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              jump_req,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              ex_busy,
  input  logic              mem_busy,
  input  logic              dbg_halt_req,
  input  logic              dbg_resume_req,
  input  logic              dbg_step_req,
  output logic              pc_hold,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_load_addr,
  output logic              if_id_hold,
  output logic              id_ex_hold,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              halted,
  output logic              stall_timeout
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  ctrl_state_t   state;
  ctrl_state_t   state_next;
  logic [DW-1:0] drain_cnt;
  logic          busy;

  assign busy = ex_busy | mem_busy;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
      halted    <= 1'b0;
    end else begin
      state  <= state_next;
      halted <= (state_next == ST_HALTED);
      if (state_next == ST_DRAIN && state != ST_DRAIN) begin
        drain_cnt <= '0;
      end else if (state == ST_DRAIN && !busy) begin
        drain_cnt <= drain_cnt + DW'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN: begin
        if (dbg_halt_req) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!busy && drain_cnt == DW'(DRAIN_CYCLES - 1)) state_next = ST_HALTED;
      end
      ST_HALTED: begin
        if (dbg_resume_req)    state_next = ST_RUN;
        else if (dbg_step_req) state_next = ST_STEP;
      end
      ST_STEP: begin
        if (!busy) state_next = ST_DRAIN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  // Priority: reset, then busy freeze, then halted freeze, then jump, then drain.
  always_comb begin
    pc_hold      = 1'b0;
    pc_load      = 1'b0;
    pc_load_addr = '0;
    if_id_hold   = 1'b0;
    id_ex_hold   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    if (!sys_rst) begin
      if (busy || state == ST_HALTED) begin
        pc_hold    = 1'b1;
        if_id_hold = 1'b1;
        id_ex_hold = 1'b1;
      end else if (jump_req) begin
        pc_load      = 1'b1;
        pc_load_addr = jump_addr;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
      end else if (state == ST_DRAIN) begin
        pc_hold     = 1'b1;
        if_id_flush = 1'b1;
      end
    end
  end

  stall_watchdog #(
    .STALL_LIMIT(STALL_LIMIT)
  ) u_stall_watchdog (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .busy         (busy),
    .stall_timeout(stall_timeout)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random traffic,
// compared every cycle against a behavioural model of the control rules.
module tb_pipe_ctrl;

  localparam int STALL_LIMIT  = 8;
  localparam int DRAIN_CYCLES = 2;

  logic        sys_clk        = 1'b0;
  logic        sys_rst        = 1'b1;
  logic        jump_req       = 1'b0;
  logic [31:0] jump_addr      = '0;
  logic        ex_busy        = 1'b0;
  logic        mem_busy       = 1'b0;
  logic        dbg_halt_req   = 1'b0;
  logic        dbg_resume_req = 1'b0;
  logic        dbg_step_req   = 1'b0;
  logic        pc_hold, pc_load, if_id_hold, id_ex_hold;
  logic        if_id_flush, id_ex_flush, halted, stall_timeout;
  logic [31:0] pc_load_addr;

  int num_checks = 0;
  int num_errors = 0;

  // Model: halted flag, remaining drain cycles, pending single step, busy run.
  bit m_halted    = 1'b0;
  int m_drain     = 0;
  bit m_stepping  = 1'b0;
  int m_busy_run  = 0;
  bit m_timeout   = 1'b0;

  pipe_ctrl #(
    .ADDR_W      (32),
    .STALL_LIMIT (STALL_LIMIT),
    .DRAIN_CYCLES(DRAIN_CYCLES)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .jump_req      (jump_req),
    .jump_addr     (jump_addr),
    .ex_busy       (ex_busy),
    .mem_busy      (mem_busy),
    .dbg_halt_req  (dbg_halt_req),
    .dbg_resume_req(dbg_resume_req),
    .dbg_step_req  (dbg_step_req),
    .pc_hold       (pc_hold),
    .pc_load       (pc_load),
    .pc_load_addr  (pc_load_addr),
    .if_id_hold    (if_id_hold),
    .id_ex_hold    (id_ex_hold),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .halted        (halted),
    .stall_timeout (stall_timeout)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", tag, $time, observed, expected);
    end
  endtask

  // One cycle: drive at negedge, check shortly after, advance model at posedge.
  task automatic applyStimulus(input bit rst, input bit ex, input bit mem,
                               input bit jmp, input logic [31:0] addr,
                               input bit hlt, input bit res, input bit stp);
    bit busy;
    logic [5:0] exp_ctrl;
    logic [31:0] exp_addr;
    @(negedge sys_clk);
    sys_rst = rst; ex_busy = ex; mem_busy = mem; jump_req = jmp; jump_addr = addr;
    dbg_halt_req = hlt; dbg_resume_req = res; dbg_step_req = stp;
    #1;
    busy     = ex | mem;
    exp_ctrl = '0;
    exp_addr = '0;
    // exp_ctrl = {pc_hold, pc_load, if_id_hold, id_ex_hold, if_id_flush, id_ex_flush}
    if (rst)                   exp_ctrl = 6'b000000;
    else if (busy || m_halted) exp_ctrl = 6'b101100;
    else if (jmp) begin
      exp_ctrl = 6'b010011;
      exp_addr = addr;
    end else if (m_drain > 0)  exp_ctrl = 6'b100010;
    checkOutput("ctrl", {26'd0, pc_hold, pc_load, if_id_hold, id_ex_hold, if_id_flush, id_ex_flush},
                {26'd0, exp_ctrl});
    if (rst || exp_ctrl[4]) checkOutput("pc_load_addr", pc_load_addr, exp_addr);
    checkOutput("halted", {31'd0, halted}, {31'd0, m_halted});
    checkOutput("stall_timeout", {31'd0, stall_timeout}, {31'd0, m_timeout});
    @(posedge sys_clk);
    if (rst) begin
      m_halted = 0; m_drain = 0; m_stepping = 0; m_busy_run = 0; m_timeout = 0;
    end else begin
      if (busy) begin
        m_busy_run = (m_busy_run < STALL_LIMIT) ? m_busy_run + 1 : STALL_LIMIT;
        if (m_busy_run >= STALL_LIMIT) m_timeout = 1;
      end else begin
        m_busy_run = 0;
      end
      if (m_halted) begin
        if (res) m_halted = 0;
        else if (stp) begin
          m_halted = 0; m_stepping = 1;
        end
      end else if (m_stepping) begin
        if (!busy) begin
          m_stepping = 0; m_drain = DRAIN_CYCLES;
        end
      end else if (m_drain > 0) begin
        if (!busy) begin
          m_drain--;
          if (m_drain == 0) m_halted = 1;
        end
      end else if (hlt) begin
        m_drain = DRAIN_CYCLES;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 32'h0, 0, 0, 0);
  endtask

  initial begin
    int burst;
    logic [31:0] addr;
    burst = 0;
    $display("[TB] starting pipe_ctrl bench");
    repeat (2) applyStimulus(1, 0, 0, 1, 32'h1234, 1, 0, 0);
    idle(3);
    // Jump in RUN, then a jump held across a 5-cycle EX stall.
    applyStimulus(0, 0, 0, 1, 32'h0000_0040, 0, 0, 0);
    repeat (5) applyStimulus(0, 1, 0, 1, 32'h0000_0080, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'h0000_0080, 0, 0, 0);
    idle(2);
    // Halt, then step, then step+resume together.
    applyStimulus(0, 0, 0, 0, 32'h0, 1, 0, 0);
    idle(5);
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 0, 1);
    idle(5);
    applyStimulus(0, 0, 0, 1, 32'h0000_0100, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 1, 1);
    idle(2);
    // Watchdog just below and exactly at the limit.
    repeat (STALL_LIMIT - 1) applyStimulus(0, 0, 1, 0, 32'h0, 0, 0, 0);
    idle(2);
    repeat (STALL_LIMIT) applyStimulus(0, 0, 1, 0, 32'h0, 0, 0, 0);
    idle(3);
    // Reset while halted.
    applyStimulus(0, 0, 0, 0, 32'h0, 1, 0, 0);
    idle(4);
    applyStimulus(1, 0, 0, 0, 32'h0, 0, 0, 0);
    idle(2);
    // Random traffic with occasional long memory stalls and rare resets.
    for (int i = 0; i < 600; i++) begin
      bit rst, ex, mem, jmp;
      if (burst == 0 && $urandom_range(0, 19) == 0) burst = $urandom_range(4, 12);
      mem = (burst > 0) || ($urandom_range(0, 5) == 0);
      if (burst > 0) burst--;
      ex   = ($urandom_range(0, 5) == 0);
      jmp  = ($urandom_range(0, 4) == 0);
      rst  = ($urandom_range(0, 79) == 0);
      addr = $urandom & 32'hFFFF_FFFC;
      applyStimulus(rst, ex, mem, jmp, addr, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the 3-stage RV32 core (PC → IF/ID → ID/EX → EX). It has two jobs. First, it turns jump requests from EX and busy indications from multi-cycle EX ops or the data memory into PC load, hold and flush controls for the PC, `if_id` and `id_ex` stages. Second, it runs a debug run/halt/step state machine and a stall watchdog. All pipeline registers take their hold/flush from this block; no stage decides its own.

## Interface
Parameters:
- `ADDR_W`, 32, instruction address width
- `STALL_LIMIT`, 1024, consecutive busy cycles before watchdog trip (≥2)
- `DRAIN_CYCLES`, 2, non-busy cycles needed to empty IF/ID and ID/EX

Ports:
- `sys_clk` in 1: single clock, all state on rising edge
- `sys_rst` in 1: synchronous reset, active-high
- `jump_req` in 1: EX resolves a taken branch/jump this cycle
- `jump_addr` in ADDR_W: jump target, valid with `jump_req`
- `ex_busy` in 1: multi-cycle EX op not finished
- `mem_busy` in 1: data memory not ready
- `dbg_halt_req` / `dbg_resume_req` / `dbg_step_req` in 1 each: single-cycle debug pulses
- `pc_hold` out 1: PC keeps its value
- `pc_load` out 1: PC takes `pc_load_addr`
- `pc_load_addr` out ADDR_W: new PC
- `if_id_hold`, `id_ex_hold` out 1: stage register keeps its contents
- `if_id_flush`, `id_ex_flush` out 1: stage register loads NOP (0x00000013), `rd_wen`=0
- `halted` out 1: core halted, pipeline empty
- `stall_timeout` out 1: sticky watchdog flag

## Operation
- `busy` = `ex_busy | mem_busy`.
- **Busy, any state:** `pc_hold` = `if_id_hold` = `id_ex_hold` = 1. All flushes and `pc_load` = 0. `jump_req` is ignored; EX re-presents it because ID/EX is frozen.
- **Not busy, `jump_req`:** `pc_load` = 1, `pc_load_addr` = `jump_addr`, `if_id_flush` = `id_ex_flush` = 1.
  - This applies in every state except HALTED.
  - `pc_load` overrides `pc_hold`, so `pc_hold` = 0 that cycle.
  - Flush overrides hold.
- **FSM states:** RUN, DRAIN, HALTED, STEP. Transitions evaluate only the request pulses in the current cycle.
- **RUN:** no holds unless busy.
  - `dbg_halt_req` → DRAIN. Halt beats step when both are asserted.
  - Resume/step pulses in RUN are ignored.
- **DRAIN:** `pc_hold` = 1 and `if_id_flush` = 1, so the fetched instruction is discarded and refetched later.
  - `drain_cnt` clears on entry and increments on each non-busy cycle.
  - On the cycle `drain_cnt` == `DRAIN_CYCLES`−1 and not busy → HALTED.
  - A jump during DRAIN is taken as normal: the PC is redirected and `drain_cnt` is unaffected.
  - All debug pulses are ignored.
- **HALTED:** `pc_hold` = `if_id_hold` = `id_ex_hold` = 1, `halted` = 1.
  - `dbg_resume_req` → RUN. Resume beats step.
  - `dbg_step_req` → STEP.
  - Halt pulses are ignored.
- **STEP:** lasts exactly one cycle. No holds and no flushes, so one instruction enters IF/ID; the next state is DRAIN.
  - If busy, STEP stays in STEP until not busy.
- **Watchdog:** `stall_cnt` increments on each busy cycle, clears on each non-busy cycle, and saturates at `STALL_LIMIT`.
  - `stall_timeout` sets when `stall_cnt` reaches `STALL_LIMIT`.
  - It is sticky until `sys_rst`. It has no effect on the pipeline.

## Timing
- Hold, flush and `pc_load` outputs are combinational from inputs and the registered state, with zero latency. Stages apply them at the next `sys_clk` edge.
- `halted` and `stall_timeout` are registered.
- Reset, while `sys_rst` is high and on the first cycle after:
  - state = RUN, `drain_cnt` = 0, `stall_cnt` = 0.
  - `halted` = 0, `stall_timeout` = 0.
  - All combinational outputs are forced to 0, with `pc_load_addr` = 0.
- Reset mid-DRAIN or mid-HALTED returns the FSM to RUN; it does not remember a pending halt.
- Halt-to-`halted` latency with no busy and no jump: DRAIN_CYCLES + 1 edges after the pulse edge (3 at the defaults).
- `stall_timeout` rises on the edge where the STALL_LIMIT-th consecutive busy cycle completes.

## Structure
- Shared package `rv_ctrl_pkg`: state encodings (RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2, STEP = 2'd3), NOP constant 32'h00000013, default `STALL_LIMIT` and `DRAIN_CYCLES`.
- One sub-module, `stall_watchdog`: the saturating counter plus the sticky flag, parameterised by `STALL_LIMIT`.
- The top-level holds the FSM, `drain_cnt` and the output priority logic.

## Test plan
- `jump_req` = 1, `jump_addr` = 0x00000040, not busy, RUN → same cycle: `pc_load` = 1, `pc_load_addr` = 0x40, both flushes = 1, `pc_hold` = 0.
- `ex_busy` high 5 cycles with `jump_req` = 1 throughout → all three holds = 1 and `pc_load` = 0 for 5 cycles; on the 6th cycle `pc_load` = 1 and both flushes = 1.
- `dbg_halt_req` pulse at cycle 10, no busy → DRAIN in cycles 11–12 with `pc_hold` = 1 and `if_id_flush` = 1; `halted` = 1 from cycle 13; PC value unchanged from cycle 11.
- From HALTED, `dbg_step_req` → exactly one cycle with `pc_hold` = 0, then DRAIN for 2 cycles, then `halted` = 1 again. `dbg_step_req` and `dbg_resume_req` in the same cycle → RUN.
- `STALL_LIMIT` = 8: `mem_busy` high 7 cycles then low → `stall_timeout` stays 0. `mem_busy` high 8 cycles → `stall_timeout` = 1 and stays 1 after busy drops, until `sys_rst`.
- `sys_rst` asserted while HALTED → next cycle: state RUN, `halted` = 0, all holds = 0.
